uart_cmd_decoder: RTL and testbench

Byte-level command decoder sitting directly downstream of the UART receiver and upstream of the UART transmitter. It consumes received bytes and assembles register-file write frames (0xAA, addr, data) and read frames (0xBB, addr). It issues single-cycle register-file strobes and, for reads, returns the read byte to the transmitter using its valid/busy handshake.

---
 rtl/uart_cmd_decoder.sv | 165 ++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_decoder
// Purpose  : Turns UART RX bytes into register-file write (0xAA,addr,data) and
//            read (0xBB,addr) frames; read data is handed to the UART TX.
//            Optional macro CMD_TIMEOUT_EN adds an inter-byte timeout.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_decoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WIDTH-1:0] RF_RdData,
  input  logic                  RF_RdData_VLD,
  input  logic                  TX_Busy,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  CMD_ERR
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } state_t;

  localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'hBB);

  state_t                state, state_next;
  logic                  wr_en_next, rd_en_next, tx_vld_next, err_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] wdata_next, txdata_next;
  logic                  timeout;

`ifdef CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             timed_state;
  logic             progress;

  assign timed_state = (state == WR_ADDR) || (state == WR_DATA) ||
                       (state == RD_ADDR) || (state == RD_WAIT);
  // Bytes in RD_WAIT are dropped, so only read data counts as progress there.
  assign progress    = (state == RD_WAIT) ? RF_RdData_VLD : RX_D_VLD;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      tmo_cnt <= '0;
    else if (!timed_state || progress || (state_next != state))
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout = timed_state && !progress &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // No timeout: frame states wait indefinitely.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      TX_D_VLD   <= 1'b0;
      CMD_ERR    <= 1'b0;
      RF_Address <= '0;
      RF_WrData  <= '0;
      TX_P_DATA  <= '0;
    end else begin
      state      <= state_next;
      RF_WrEn    <= wr_en_next;
      RF_RdEn    <= rd_en_next;
      TX_D_VLD   <= tx_vld_next;
      CMD_ERR    <= err_next;
      RF_Address <= addr_next;
      RF_WrData  <= wdata_next;
      TX_P_DATA  <= txdata_next;
    end
  end

  always_comb begin
    state_next  = state;
    wr_en_next  = 1'b0;
    rd_en_next  = 1'b0;
    tx_vld_next = 1'b0;
    err_next    = 1'b0;
    addr_next   = RF_Address;
    wdata_next  = RF_WrData;
    txdata_next = TX_P_DATA;
    case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_WR)      state_next = WR_ADDR;
          else if (RX_P_DATA == CMD_RD) state_next = RD_ADDR;
          else                          err_next   = 1'b1;
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_next  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_next = WR_DATA;
        end else if (timeout) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wdata_next = RX_P_DATA;
          wr_en_next = 1'b1;
          state_next = IDLE;
        end else if (timeout) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_next  = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_next = 1'b1;
          state_next = RD_WAIT;
        end else if (timeout) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      RD_WAIT: begin
        if (RX_D_VLD) err_next = 1'b1;
        if (RF_RdData_VLD) begin
          txdata_next = RF_RdData;
          state_next  = TX_SEND;
        end else if (timeout) begin
          err_next    = 1'b1;
          state_next  = IDLE;
        end
      end
      TX_SEND: begin
        if (RX_D_VLD) err_next = 1'b1;
        if (!TX_Busy) begin
          tx_vld_next = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// Testbench for uart_cmd_decoder: directed frames plus randomized frames
// checked against a frame-level reference model.
module tb_uart_cmd_decoder;
  localparam int TMO = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic [7:0] RF_RdData;
  logic       RF_RdData_VLD;
  logic       TX_Busy;
  logic       RF_WrEn, RF_RdEn, TX_D_VLD, CMD_ERR;
  logic [3:0] RF_Address;
  logic [7:0] RF_WrData, TX_P_DATA;

  uart_cmd_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD), .TX_Busy(TX_Busy),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0, n_mis = 0;
  int last_rx_cyc = 0;

  // Event log of DUT strobes, sampled just after each rising edge.
  int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, err_cnt = 0;
  int wr_cyc = 0, rd_cyc = 0, tx_cyc = 0, err_cyc = 0;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, tx_data;
  always @(posedge CLK) begin
    #1;
    if (RF_WrEn === 1'b1) begin wr_cnt++; wr_cyc = cyc; wr_addr = RF_Address; wr_data = RF_WrData; end
    if (RF_RdEn === 1'b1) begin rd_cnt++; rd_cyc = cyc; rd_addr = RF_Address; end
    if (TX_D_VLD === 1'b1) begin tx_cnt++; tx_cyc = cyc; tx_data = TX_P_DATA; end
    if (CMD_ERR === 1'b1) begin err_cnt++; err_cyc = cyc; end
  end

  // Reference register file seen by the read path.
  logic [7:0] mem [16];

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b; RX_D_VLD = 1'b1;
    @(negedge CLK);
    RX_D_VLD = 1'b0;
    last_rx_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Read frame stimulus; drop=1 byte in RD_WAIT before data, drop=2 byte coincides with data.
  task automatic rd_frame(input logic [7:0] a, input int lat, input int busy,
                          input logic [7:0] rdata, input int drop,
                          output int rel, output int rx);
    TX_Busy = (busy > 0);
    send_byte(8'hBB);
    send_byte(a);
    rx = last_rx_cyc;
    if (drop == 1) send_byte(8'h99);
    repeat (lat) @(negedge CLK);
    RF_RdData = rdata; RF_RdData_VLD = 1'b1;
    if (drop == 2) begin RX_P_DATA = 8'h99; RX_D_VLD = 1'b1; end
    @(negedge CLK);
    RF_RdData_VLD = 1'b0; RX_D_VLD = 1'b0;
    repeat (busy) @(negedge CLK);
    TX_Busy = 1'b0;
    rel = cyc;
  endtask

  task automatic test_reset();
    RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 1'b0; RF_RdData = '0;
    RF_RdData_VLD = 1'b0; TX_Busy = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_P_DATA, TX_D_VLD, CMD_ERR} !== 24'h0) begin
      n_mis++;
      $display("FAIL reset_outputs: got %h exp 0",
               {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_P_DATA, TX_D_VLD, CMD_ERR});
    end
    RST = 1'b0;
    idle(1);
  endtask

  task automatic test_write();
    int w0, e0, t;
    w0 = wr_cnt; e0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    t = last_rx_cyc;
    idle(3);
    n_cmp++; if (wr_cnt !== w0 + 1) begin n_mis++; $display("FAIL wr_count: got %0d exp %0d", wr_cnt, w0 + 1); end
    n_cmp++; if (wr_addr !== 4'h5) begin n_mis++; $display("FAIL wr_addr: got %h exp 5", wr_addr); end
    n_cmp++; if (wr_data !== 8'h3C) begin n_mis++; $display("FAIL wr_data: got %h exp 3c", wr_data); end
    n_cmp++; if (wr_cyc !== t) begin n_mis++; $display("FAIL wr_timing: got %0d exp %0d", wr_cyc, t); end
    n_cmp++; if (err_cnt !== e0) begin n_mis++; $display("FAIL wr_no_err: got %0d exp %0d", err_cnt, e0); end
  endtask

  task automatic test_read();
    int r0, t0, e0, rel, rx;
    r0 = rd_cnt; t0 = tx_cnt; e0 = err_cnt;
    rd_frame(8'h0A, 3, 10, 8'h77, 0, rel, rx);
    for (int k = 0; k < 30 && tx_cnt == t0; k++) @(negedge CLK);
    idle(3);
    n_cmp++; if (rd_cnt !== r0 + 1) begin n_mis++; $display("FAIL rd_count: got %0d exp %0d", rd_cnt, r0 + 1); end
    n_cmp++; if (rd_addr !== 4'hA) begin n_mis++; $display("FAIL rd_addr: got %h exp a", rd_addr); end
    n_cmp++; if (rd_cyc !== rx) begin n_mis++; $display("FAIL rd_timing: got %0d exp %0d", rd_cyc, rx); end
    n_cmp++; if (tx_cnt !== t0 + 1) begin n_mis++; $display("FAIL tx_count: got %0d exp %0d", tx_cnt, t0 + 1); end
    n_cmp++; if (tx_data !== 8'h77) begin n_mis++; $display("FAIL tx_data: got %h exp 77", tx_data); end
    n_cmp++; if (tx_cyc !== rel + 1) begin n_mis++; $display("FAIL tx_timing: got %0d exp %0d", tx_cyc, rel + 1); end
    n_cmp++; if (TX_P_DATA !== 8'h77) begin n_mis++; $display("FAIL tx_hold: got %h exp 77", TX_P_DATA); end
    n_cmp++; if (err_cnt !== e0) begin n_mis++; $display("FAIL rd_no_err: got %0d exp %0d", err_cnt, e0); end
  endtask

  task automatic test_invalid();
    int w0, e0, t;
    w0 = wr_cnt; e0 = err_cnt;
    send_byte(8'h12);
    t = last_rx_cyc;
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
    idle(2);
    n_cmp++; if (err_cnt !== e0 + 1) begin n_mis++; $display("FAIL inv_err: got %0d exp %0d", err_cnt, e0 + 1); end
    n_cmp++; if (err_cyc !== t) begin n_mis++; $display("FAIL inv_err_timing: got %0d exp %0d", err_cyc, t); end
    n_cmp++; if (wr_cnt !== w0 + 1 || wr_addr !== 4'h1 || wr_data !== 8'hFF) begin
      n_mis++; $display("FAIL inv_then_write: got cnt %0d addr %h data %h exp cnt %0d addr 1 data ff",
                        wr_cnt, wr_addr, wr_data, w0 + 1);
    end
  endtask

  task automatic test_reset_mid();
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h03);
    idle(1);
    #2 RST = 1'b1;
    #1;
    n_cmp++;
    if ({RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_P_DATA, TX_D_VLD, CMD_ERR} !== 24'h0) begin
      n_mis++;
      $display("FAIL async_reset_outputs: got %h exp 0",
               {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_P_DATA, TX_D_VLD, CMD_ERR});
    end
    @(negedge CLK);
    RST = 1'b0;
    idle(1);
    send_byte(8'h55);
    idle(2);
    n_cmp++; if (wr_cnt !== w0) begin n_mis++; $display("FAIL reset_abort_wr: got %0d exp %0d", wr_cnt, w0); end
    n_cmp++; if (err_cnt !== e0 + 1) begin n_mis++; $display("FAIL reset_then_err: got %0d exp %0d", err_cnt, e0 + 1); end
  endtask

  task automatic test_timeout();
    int w0, e0, r0, t0, t;
    w0 = wr_cnt; e0 = err_cnt; r0 = rd_cnt; t0 = tx_cnt;
`ifdef CMD_TIMEOUT_EN
    send_byte(8'hBB);
    t = last_rx_cyc;
    for (int k = 0; k < 40 && err_cnt == e0; k++) @(negedge CLK);
    n_cmp++; if (err_cnt !== e0 + 1) begin n_mis++; $display("FAIL tmo_err: got %0d exp %0d", err_cnt, e0 + 1); end
    n_cmp++; if (err_cyc !== t + TMO) begin n_mis++; $display("FAIL tmo_timing: got %0d exp %0d", err_cyc, t + TMO); end
    n_cmp++; if (rd_cnt !== r0) begin n_mis++; $display("FAIL tmo_no_rd: got %0d exp %0d", rd_cnt, r0); end
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h5A);
    idle(2);
    n_cmp++; if (wr_cnt !== w0 + 1 || wr_addr !== 4'h2 || wr_data !== 8'h5A) begin
      n_mis++; $display("FAIL tmo_then_write: got cnt %0d addr %h data %h exp cnt %0d addr 2 data 5a",
                        wr_cnt, wr_addr, wr_data, w0 + 1);
    end
`else
    send_byte(8'hBB);
    idle(3 * TMO);
    n_cmp++; if (err_cnt !== e0) begin n_mis++; $display("FAIL no_tmo_err: got %0d exp %0d", err_cnt, e0); end
    send_byte(8'h06);
    t = last_rx_cyc;
    RF_RdData = 8'h6E; RF_RdData_VLD = 1'b1;
    @(negedge CLK);
    RF_RdData_VLD = 1'b0;
    for (int k = 0; k < 30 && tx_cnt == t0; k++) @(negedge CLK);
    idle(1);
    n_cmp++; if (rd_cnt !== r0 + 1 || rd_addr !== 4'h6 || rd_cyc !== t) begin
      n_mis++; $display("FAIL no_tmo_read: got cnt %0d addr %h cyc %0d exp cnt %0d addr 6 cyc %0d",
                        rd_cnt, rd_addr, rd_cyc, r0 + 1, t);
    end
    n_cmp++; if (tx_cnt !== t0 + 1 || tx_data !== 8'h6E) begin
      n_mis++; $display("FAIL no_tmo_tx: got cnt %0d data %h exp cnt %0d data 6e", tx_cnt, tx_data, t0 + 1);
    end
    n_cmp++; if (wr_cnt !== w0) begin n_mis++; $display("FAIL no_tmo_no_wr: got %0d exp %0d", wr_cnt, w0); end
`endif
  endtask

  task automatic test_dropped();
    for (int mode = 1; mode <= 2; mode++) begin
      int t0, e0, rel, rx;
      logic [7:0] d;
      d = 8'($urandom);
      t0 = tx_cnt; e0 = err_cnt;
      rd_frame(8'($urandom), 2, mode, d, mode, rel, rx);
      for (int k = 0; k < 30 && tx_cnt == t0; k++) @(negedge CLK);
      idle(1);
      n_cmp++; if (err_cnt !== e0 + 1) begin n_mis++; $display("FAIL drop%0d_err: got %0d exp %0d", mode, err_cnt, e0 + 1); end
      n_cmp++; if (tx_cnt !== t0 + 1 || tx_data !== d || tx_cyc !== rel + 1) begin
        n_mis++; $display("FAIL drop%0d_tx: got cnt %0d data %h cyc %0d exp cnt %0d data %h cyc %0d",
                          mode, tx_cnt, tx_data, tx_cyc, t0 + 1, d, rel + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h07); send_byte(8'h11);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hAA);
    idle(2);
    n_cmp++; if (wr_cnt !== w0 + 2) begin n_mis++; $display("FAIL b2b_count: got %0d exp %0d", wr_cnt, w0 + 2); end
    n_cmp++; if (wr_addr !== 4'hB || wr_data !== 8'hAA) begin
      n_mis++; $display("FAIL b2b_last: got addr %h data %h exp addr b data aa", wr_addr, wr_data);
    end
    n_cmp++; if (err_cnt !== e0) begin n_mis++; $display("FAIL b2b_err: got %0d exp %0d", err_cnt, e0); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      int kind, w0, r0, t0, e0, rel, rx, t;
      logic [7:0] a, d;
      kind = $urandom_range(0, 2);
      a = 8'($urandom); d = 8'($urandom);
      w0 = wr_cnt; r0 = rd_cnt; t0 = tx_cnt; e0 = err_cnt;
      if (kind == 0) begin
        send_byte(8'hAA); idle($urandom_range(0, 2));
        send_byte(a);     idle($urandom_range(0, 2));
        send_byte(d);
        t = last_rx_cyc;
        mem[a[3:0]] = d;
        idle(1);
        n_cmp++; if (wr_cnt !== w0 + 1 || wr_addr !== a[3:0] || wr_data !== d || wr_cyc !== t) begin
          n_mis++; $display("FAIL rnd%0d_wr: got cnt %0d addr %h data %h cyc %0d exp cnt %0d addr %h data %h cyc %0d",
                            f, wr_cnt, wr_addr, wr_data, wr_cyc, w0 + 1, a[3:0], d, t);
        end
      end else if (kind == 1) begin
        rd_frame(a, $urandom_range(0, 3), $urandom_range(0, 3), mem[a[3:0]], 0, rel, rx);
        for (int k = 0; k < 30 && tx_cnt == t0; k++) @(negedge CLK);
        n_cmp++; if (rd_cnt !== r0 + 1 || rd_addr !== a[3:0] || rd_cyc !== rx) begin
          n_mis++; $display("FAIL rnd%0d_rd: got cnt %0d addr %h cyc %0d exp cnt %0d addr %h cyc %0d",
                            f, rd_cnt, rd_addr, rd_cyc, r0 + 1, a[3:0], rx);
        end
        n_cmp++; if (tx_cnt !== t0 + 1 || tx_data !== mem[a[3:0]] || tx_cyc !== rel + 1) begin
          n_mis++; $display("FAIL rnd%0d_tx: got cnt %0d data %h cyc %0d exp cnt %0d data %h cyc %0d",
                            f, tx_cnt, tx_data, tx_cyc, t0 + 1, mem[a[3:0]], rel + 1);
        end
      end else begin
        while (a == 8'hAA || a == 8'hBB) a = 8'($urandom);
        send_byte(a);
        t = last_rx_cyc;
        idle(1);
        n_cmp++; if (err_cnt !== e0 + 1 || err_cyc !== t) begin
          n_mis++; $display("FAIL rnd%0d_inv: got cnt %0d cyc %0d exp cnt %0d cyc %0d",
                            f, err_cnt, err_cyc, e0 + 1, t);
        end
      end
      if (kind != 2) begin
        n_cmp++; if (err_cnt !== e0) begin n_mis++; $display("FAIL rnd%0d_no_err: got %0d exp %0d", f, err_cnt, e0); end
      end
      idle($urandom_range(0, 1));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    test_reset();
    test_write();
    test_read();
    test_invalid();
    test_reset_mid();
    test_timeout();
    test_dropped();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
